par_resp_gen: RTL
=================

Name: par_resp_gen

Overview:
- Responder side of the delayed request/response handshake. A rising edge on request `a` must produce a one-cycle response pulse on `b` exactly `delay` cycles later.
- Each response carries a data word and an even-parity bit, so `^(data^parity)==0` holds in every cycle.
- Used as the stimulus/DUT end of the handshake and as the parity-protected word source for the parity-checking path.

Parameters:
- WIDTH, 32, data word width
- DW, 4, width of the delay input (max delay 2**DW-1)
- DEPTH, 4, number of outstanding scheduled responses (delay >= 2)

Ports:
- clk  input  1  rising-edge clock
- rst_  input  1  asynchronous, active-high reset
- a  input  1  request; its rising edge starts a transaction
- delay  input  DW  response latency in cycles; sampled only at a rising edge of `a`
- din  input  WIDTH  payload; sampled only at a rising edge of `a`
- b  output  1  response pulse, one cycle per accepted request
- data  output  WIDTH  payload, valid while b=1, otherwise 0
- parity  output  1  equals ^data in every cycle
- drop  output  1  one-cycle pulse: request rejected
- busy  output  1  at least one slot valid

Behaviour:
- Reset (async assert, sync release): a_q, b_q, data_q, parity_q, drop_q and all slot valid bits are 0. b, data, parity, drop and busy read 0 during reset.
- Rise detect: rose = a & ~a_q; a_q <= a every edge. With `a` held high, there is no retrigger. If `a` is high at the first edge after reset, that edge counts as a rise.
- Let T be the edge where rose=1 and d=delay. The required result is b=1 at edge T+d, with data=din(T) and parity=^din(T).
- d=0, combinational bypass:
  - b = b_q | byp0, where byp0 = rose & (d==0) & ~b_q.
  - data = byp0 ? din : data_q; parity likewise.
  - The only combinational path is a/delay/din -> b/data/parity.
- d=1: at edge T, b_q<=1, data_q<=din, parity_q<=^din. No slot is used.
- d>=2: allocate the lowest-index free slot at edge T with cnt=d-1 and payload din.
- Slot update each edge:
  - If valid and cnt==1: fire (b_q<=1, data_q/parity_q<=payload) and clear valid.
  - Otherwise, if valid: cnt<=cnt-1.
- When nothing fires and there is no d=1 request: b_q<=0, data_q<=0, parity_q<=0.
- Collision rule (at most one response per cycle), evaluated at edge T. The new request is dropped when:
  - d=0 and b_q==1;
  - d>=1 and any valid slot has cnt==d;
  - d>=2 and all DEPTH slots are valid.
- On a dropped request: drop_q<=1 for one cycle. Existing slots are unaffected, and no b is produced for the dropped request.
- A slot freed by firing at edge T is not reusable by a request at the same edge T. busy reflects slot valid bits after the edge.
- Wrap/limits: d=2**DW-1 is legal. cnt is DW bits wide and never underflows.
- Reset mid-operation: all pending responses are discarded and no late b pulse appears after release.
- Parity: parity_q is always ^data_q. Invariant: parity == ^data in every cycle, including reset and idle.

Decomposition:
- Package par_resp_pkg holds:
  - typedef slot_t {logic valid; logic [DW-1:0] cnt; logic [WIDTH-1:0] payload;}
  - localparams DW_DEF, WIDTH_DEF, DEPTH_DEF
  - function even_par(word)
- Sub-module par_resp_slot: one slot's load/decrement/fire logic with inputs load, d, din and outputs fire, cnt, valid, payload. Instantiated DEPTH times.
- The top module holds rise detect, allocation priority, collision compare, output mux and the registers.

Test Plan:
- Reset mid-flight: delay=5 request pending, assert rst_ two cycles later for one cycle -> b stays 0 for the next 10 cycles; busy=0, drop=0.
- Basic latency: rose(a) at edge 10 with delay=3, din=32'h0000_0007 -> b=1 only at edge 13, data=32'h7, parity=1; drop=0.
- Zero and one delay: rose at edge 5 with delay=0, din=32'hFFFF_FFFF -> b=1 at edge 5 combinationally, data=32'hFFFF_FFFF, parity=0. Separately, delay=1 -> b=1 at edge 6 only.
- Overlap and collision:
  - rose at edge 0 with delay=6 (target 6); rose at edge 2 with delay=4 (target 6) -> second is dropped, drop=1 at edge 3, single b at edge 6.
  - rose at edge 4 with delay=5 -> accepted, b at edge 9.
- Full: four requests at edges 0, 2, 4, 6 with delay=15 -> all accepted, busy=1. A fifth at edge 8 with delay=14 -> drop=1 at edge 9. b occurs at edges 15, 17, 19, 21.
- Parity sweep: 1000 random requests with delay 0..15 and random din -> the property ^(data^parity)==0 never fails, and $rose(a) |-> ##(delay) b holds for every non-dropped request.

Source files
------------

// File: rtl/par_resp_pkg.sv
// Shared types, default parameters and helpers for the parity-protected
// delayed-response generator.
//   slot_t    : one scheduled response (valid flag, countdown, payload)
//   even_par  : even-parity bit of a word, zero-extended to PAR_MAX_W bits
package par_resp_pkg;

    localparam int DW_DEF    = 4;
    localparam int WIDTH_DEF = 32;
    localparam int DEPTH_DEF = 4;

    // Widest word even_par accepts; callers cast up to this width so
    // that any WIDTH up to this limit can share one function.
    localparam int PAR_MAX_W = 256;

    typedef struct packed {
        logic                 valid;
        logic [DW_DEF-1:0]    cnt;
        logic [WIDTH_DEF-1:0] payload;
    } slot_t;

    // Even parity: XOR of the word, so {word, even_par(word)} has an even
    // number of ones.
    function automatic logic even_par(input logic [PAR_MAX_W-1:0] word);
        return ^word;
    endfunction

endpackage

// File: rtl/par_resp_slot.sv
// One outstanding-response slot.
//   clk, rst_ : clock, asynchronous active-high reset
//   load      : capture a new request (only asserted while the slot is free)
//   d         : requested delay (>= 2); countdown starts at d-1
//   din       : payload to return
//   fire      : slot is valid with count 1, response leaves at this edge
//   cnt       : current countdown
//   valid     : slot holds a pending response
//   payload   : captured payload
module par_resp_slot #(
    parameter int WIDTH = 32,
    parameter int DW    = 4
) (
    input  logic             clk,
    input  logic             rst_,
    input  logic             load,
    input  logic [DW-1:0]    d,
    input  logic [WIDTH-1:0] din,
    output logic             fire,
    output logic [DW-1:0]    cnt,
    output logic             valid,
    output logic [WIDTH-1:0] payload
);

    logic             valid_q,   valid_d;
    logic [DW-1:0]    cnt_q,     cnt_d;
    logic [WIDTH-1:0] payload_q, payload_d;

    assign fire = valid_q & (cnt_q == DW'(1));

    always_comb begin
        valid_d   = valid_q;
        cnt_d     = cnt_q;
        payload_d = payload_q;
        if (fire) begin
            valid_d = 1'b0;
        end else if (valid_q) begin
            // Count never reaches 0 while valid: it starts at >= 1 and
            // stops decrementing once it hits 1.
            cnt_d = cnt_q - DW'(1);
        end
        if (load) begin
            valid_d   = 1'b1;
            cnt_d     = d - DW'(1);
            payload_d = din;
        end
    end

    always_ff @(posedge clk or posedge rst_) begin
        if (rst_) begin
            valid_q   <= 1'b0;
            cnt_q     <= '0;
            payload_q <= '0;
        end else begin
            valid_q   <= valid_d;
            cnt_q     <= cnt_d;
            payload_q <= payload_d;
        end
    end

    assign cnt     = cnt_q;
    assign valid   = valid_q;
    assign payload = payload_q;

endmodule

// File: rtl/par_resp_gen.sv
// Delayed request/response responder with even parity.
// A rising edge on a schedules a one-cycle pulse on b exactly delay cycles
// later, carrying din on data with parity = ^data. delay=0 is answered
// combinationally, delay=1 directly by the output register, delay>=2
// through one of DEPTH countdown slots. Requests that would land in an
// already-claimed response cycle, or that find all slots busy, are
// rejected with a one-cycle drop pulse.
//   clk, rst_ : clock, asynchronous active-high reset
//   a         : request; rising edge starts a transaction
//   delay     : response latency, sampled at the rise of a
//   din       : payload, sampled at the rise of a
//   b         : response pulse
//   data      : payload while b=1, otherwise 0
//   parity    : ^data
//   drop      : request rejected (one cycle after the request edge)
//   busy      : at least one slot pending
module par_resp_gen
    import par_resp_pkg::*;
#(
    parameter int WIDTH = WIDTH_DEF,
    parameter int DW    = DW_DEF,
    parameter int DEPTH = DEPTH_DEF
) (
    input  logic             clk,
    input  logic             rst_,
    input  logic             a,
    input  logic [DW-1:0]    delay,
    input  logic [WIDTH-1:0] din,
    output logic             b,
    output logic [WIDTH-1:0] data,
    output logic             parity,
    output logic             drop,
    output logic             busy
);

    logic             a_q,      a_d;
    logic             b_q,      b_d;
    logic [WIDTH-1:0] data_q,   data_d;
    logic             parity_q, parity_d;
    logic             drop_q,   drop_d;

    logic             rose;
    logic             d_zero, d_one, d_long;
    logic             drop_cond, accept, byp0;
    logic [DEPTH-1:0] slot_load, slot_fire, slot_valid, cnt_hit;
    logic [DW-1:0]    slot_cnt     [DEPTH];
    logic [WIDTH-1:0] slot_payload [DEPTH];
    logic             fire_any;
    logic [WIDTH-1:0] fire_payload;
    logic             alloc_found;

    assign rose   = a & ~a_q;
    assign d_zero = (delay == DW'(0));
    assign d_one  = (delay == DW'(1));
    assign d_long = ~d_zero & ~d_one;

    genvar gi;
    generate
        for (gi = 0; gi < DEPTH; gi++) begin : g_slot
            par_resp_slot #(.WIDTH(WIDTH), .DW(DW)) u_slot (
                .clk     (clk),
                .rst_    (rst_),
                .load    (slot_load[gi]),
                .d       (delay),
                .din     (din),
                .fire    (slot_fire[gi]),
                .cnt     (slot_cnt[gi]),
                .valid   (slot_valid[gi]),
                .payload (slot_payload[gi])
            );
            // A slot with count c answers c cycles from now, the same
            // cycle a new request with delay c would answer in.
            assign cnt_hit[gi] = slot_valid[gi] & (slot_cnt[gi] == delay);
        end
    endgenerate

    assign drop_cond = rose & ((d_zero & b_q)
                             | (~d_zero & (|cnt_hit))
                             | (d_long & (&slot_valid)));
    assign accept    = rose & ~drop_cond;

    // Held off during reset so every output reads 0 while rst_ is high.
    assign byp0 = accept & d_zero & ~rst_;

    // Lowest-index free slot wins. Uses valid bits from before the edge,
    // so a slot firing at this edge is not reused at the same edge.
    always_comb begin
        slot_load   = '0;
        alloc_found = 1'b0;
        for (int i = 0; i < DEPTH; i++) begin
            if (!slot_valid[i] && !alloc_found) begin
                alloc_found  = 1'b1;
                slot_load[i] = accept & d_long;
            end
        end
    end

    // At most one slot fires per cycle thanks to the collision check,
    // so an OR of gated payloads is a valid mux.
    always_comb begin
        fire_any     = 1'b0;
        fire_payload = '0;
        for (int i = 0; i < DEPTH; i++) begin
            if (slot_fire[i]) begin
                fire_any     = 1'b1;
                fire_payload = fire_payload | slot_payload[i];
            end
        end
    end

    always_comb begin
        a_d      = a;
        b_d      = 1'b0;
        data_d   = '0;
        drop_d   = drop_cond;
        if (fire_any) begin
            b_d    = 1'b1;
            data_d = fire_payload;
        end else if (accept && d_one) begin
            b_d    = 1'b1;
            data_d = din;
        end
        parity_d = even_par(PAR_MAX_W'(data_d));
    end

    always_ff @(posedge clk or posedge rst_) begin
        if (rst_) begin
            a_q      <= 1'b0;
            b_q      <= 1'b0;
            data_q   <= '0;
            parity_q <= 1'b0;
            drop_q   <= 1'b0;
        end else begin
            a_q      <= a_d;
            b_q      <= b_d;
            data_q   <= data_d;
            parity_q <= parity_d;
            drop_q   <= drop_d;
        end
    end

    assign b      = b_q | byp0;
    assign data   = byp0 ? din : data_q;
    assign parity = byp0 ? even_par(PAR_MAX_W'(din)) : parity_q;
    assign drop   = drop_q;
    assign busy   = |slot_valid;

endmodule
